// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, fetches one word per bus request
// and loads the IF/ID pipeline register, honouring stall, flush and branches.
module if_fetch_unit #(
  parameter int unsigned                WORD_ADDR_W  = 30,
  parameter int unsigned                WORD_DATA_W  = 32,
  parameter logic [WORD_ADDR_W-1:0]     RESET_VECTOR = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [WORD_ADDR_W-1:0] new_pc,
  input  logic                   br_taken,
  input  logic [WORD_ADDR_W-1:0] br_addr,
  output logic                   busy,
  output logic                   bus_req,
  input  logic                   bus_grant,
  output logic                   bus_as,
  output logic [WORD_ADDR_W-1:0] bus_addr,
  output logic                   bus_rw,
  input  logic [WORD_DATA_W-1:0] bus_rd_data,
  input  logic                   bus_ready,
  output logic [WORD_ADDR_W-1:0] if_pc,
  output logic [WORD_DATA_W-1:0] if_insn,
  output logic                   if_en
);

  typedef enum logic [1:0] {
    ST_REQ    = 2'd0,
    ST_ACCESS = 2'd1,
    ST_HOLD   = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  state_t                 state;
  logic [WORD_ADDR_W-1:0] pc;
  logic [WORD_ADDR_W-1:0] pc_inc;
  logic [WORD_DATA_W-1:0] insn_buf;
  logic [WORD_DATA_W-1:0] deliver_word;
  logic                   deliver;

  assign bus_rw = 1'b1;
  assign pc_inc = pc + WORD_ADDR_W'(1);

  // A word reaches IF/ID either straight off the bus or from the stall buffer.
  assign deliver = !flush && !stall &&
                   ((state == ST_ACCESS && bus_ready) || state == ST_HOLD);
  assign deliver_word = (state == ST_HOLD) ? insn_buf : bus_rd_data;

  // busy must not see stall, otherwise the control unit forms a loop.
  always_comb begin
    busy = 1'b1;
    case (state)
      ST_REQ:    busy = 1'b1;
      ST_ACCESS: busy = !bus_ready;
      ST_HOLD:   busy = 1'b0;
      ST_DRAIN:  busy = 1'b1;
      default:   busy = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_REQ;
      pc       <= RESET_VECTOR;
      insn_buf <= '0;
      if_pc    <= '0;
      if_insn  <= '0;
      if_en    <= 1'b0;
      bus_req  <= 1'b0;
      bus_as   <= 1'b0;
      bus_addr <= '0;
    end else begin
      bus_as  <= 1'b0;
      bus_req <= 1'b1;

      case (state)
        ST_REQ: begin
          if (bus_grant) begin
            bus_as   <= 1'b1;
            bus_addr <= pc;
            // A strobe already issued must be drained even if flushed now.
            state    <= flush ? ST_DRAIN : ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (flush) begin
            state <= bus_ready ? ST_REQ : ST_DRAIN;
          end else if (bus_ready && stall) begin
            insn_buf <= bus_rd_data;
            bus_req  <= 1'b0;
            state    <= ST_HOLD;
          end else if (bus_ready) begin
            state <= ST_REQ;
          end
        end
        ST_HOLD: begin
          if (flush || !stall) begin
            state <= ST_REQ;
          end else begin
            bus_req <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (bus_ready) begin
            state <= ST_REQ;
          end
        end
        default: state <= ST_REQ;
      endcase

      if (flush) begin
        pc    <= new_pc;
        if_en <= 1'b0;
      end else if (deliver) begin
        if_insn <= deliver_word;
        if_pc   <= pc_inc;
        if_en   <= 1'b1;
        pc      <= br_taken ? br_addr : pc_inc;
      end else if (!stall) begin
        if_en <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios with literal expectations, then
// randomized bus/stall/flush/branch traffic checked against a transaction model.
module tb_if_fetch_unit;

  localparam int unsigned AW = 30;
  localparam int unsigned DW = 32;
  localparam logic [AW-1:0] RV = 30'h100;

  logic          clk;
  logic          reset;
  logic          stall;
  logic          flush;
  logic [AW-1:0] new_pc;
  logic          br_taken;
  logic [AW-1:0] br_addr;
  logic          busy;
  logic          bus_req;
  logic          bus_grant;
  logic          bus_as;
  logic [AW-1:0] bus_addr;
  logic          bus_rw;
  logic [DW-1:0] bus_rd_data;
  logic          bus_ready;
  logic [AW-1:0] if_pc;
  logic [DW-1:0] if_insn;
  logic          if_en;

  int checks   = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  if_fetch_unit #(
    .WORD_ADDR_W (AW),
    .WORD_DATA_W (DW),
    .RESET_VECTOR(RV)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .flush      (flush),
    .new_pc     (new_pc),
    .br_taken   (br_taken),
    .br_addr    (br_addr),
    .busy       (busy),
    .bus_req    (bus_req),
    .bus_grant  (bus_grant),
    .bus_as     (bus_as),
    .bus_addr   (bus_addr),
    .bus_rw     (bus_rw),
    .bus_rd_data(bus_rd_data),
    .bus_ready  (bus_ready),
    .if_pc      (if_pc),
    .if_insn    (if_insn),
    .if_en      (if_en)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks the fetch as a transaction: an outstanding bus read (possibly
  // doomed by a flush), a word parked by stall, and the PC / IF-ID contents.
  logic [AW-1:0] m_pc, m_if_pc, m_addr;
  logic [DW-1:0] m_if_insn, m_held_data, m_word;
  logic          m_if_en, m_req, m_as;
  logic          m_in_flight, m_drop, m_held, m_delivered;

  always @(posedge clk) begin
    if (reset) begin
      m_pc = RV; m_if_pc = '0; m_if_insn = '0; m_if_en = 1'b0;
      m_req = 1'b0; m_as = 1'b0; m_addr = '0;
      m_in_flight = 1'b0; m_drop = 1'b0; m_held = 1'b0; m_held_data = '0;
    end else begin
      m_delivered = 1'b0;
      m_word = '0;
      m_as = 1'b0;
      if (flush) begin
        m_if_en = 1'b0;
        if (m_in_flight) begin
          if (bus_ready) begin m_in_flight = 1'b0; m_drop = 1'b0; end
          else m_drop = 1'b1;
        end else if (m_held) begin
          m_held = 1'b0;
        end else if (bus_grant) begin
          m_as = 1'b1; m_addr = m_pc; m_in_flight = 1'b1; m_drop = 1'b1;
        end
        m_pc = new_pc;
      end else if (m_in_flight && m_drop) begin
        if (bus_ready) begin m_in_flight = 1'b0; m_drop = 1'b0; end
      end else if (m_held) begin
        if (!stall) begin m_word = m_held_data; m_delivered = 1'b1; m_held = 1'b0; end
      end else if (m_in_flight) begin
        if (bus_ready) begin
          m_in_flight = 1'b0;
          if (stall) begin m_held = 1'b1; m_held_data = bus_rd_data; end
          else begin m_word = bus_rd_data; m_delivered = 1'b1; end
        end
      end else if (bus_grant) begin
        m_as = 1'b1; m_addr = m_pc; m_in_flight = 1'b1;
      end
      if (m_delivered) begin
        m_if_insn = m_word;
        m_if_pc   = m_pc + AW'(1);
        m_if_en   = 1'b1;
        m_pc      = br_taken ? br_addr : m_pc + AW'(1);
      end else if (!flush && !stall) begin
        m_if_en = 1'b0;
      end
      m_req = !m_held;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_bus_req",  bus_req,  m_req);
      chk("cyc_bus_as",   bus_as,   m_as);
      chk("cyc_bus_addr", bus_addr, m_addr);
      chk("cyc_bus_rw",   bus_rw,   1'b1);
      chk("cyc_if_en",    if_en,    m_if_en);
      chk("cyc_if_pc",    if_pc,    m_if_pc);
      chk("cyc_if_insn",  if_insn,  m_if_insn);
      chk("cyc_busy",     busy,
          m_in_flight ? (m_drop ? 1'b1 : !bus_ready) : !m_held);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    flush = 1'b0; br_taken = 1'b0; bus_grant = 1'b0; bus_ready = 1'b0;
  endtask

  task automatic grant_cycle();
    bus_grant = 1'b1;
    cyc();
    bus_grant = 1'b0;
  endtask

  // Random bus slave: grants only when idle, returns data 0..3 cycles after a strobe.
  logic   ag_pending;
  int     ag_cnt;

  task automatic bus_step();
    bus_ready = 1'b0;
    bus_grant = 1'b0;
    if (bus_as) begin
      ag_pending = 1'b1;
      ag_cnt = $urandom_range(0, 3);
    end
    if (ag_pending) begin
      if (ag_cnt == 0) begin
        bus_ready = 1'b1;
        bus_rd_data = $urandom;
        ag_pending = 1'b0;
      end else begin
        ag_cnt--;
      end
    end else if (bus_req && $urandom_range(0, 2) != 0) begin
      bus_grant = 1'b1;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1; stall = 1'b0; new_pc = '0; br_addr = '0; bus_rd_data = '0;
    ag_pending = 1'b0; ag_cnt = 0;
    clear_ctl();
    cyc();
    chk_en = 1'b1;
    cyc();
    reset = 1'b0;

    // Reset values and first fetch
    chk("rst_if_en", if_en, 1'b0);
    chk("rst_bus_req", bus_req, 1'b0);
    chk("rst_bus_addr", bus_addr, 30'h0);
    chk("rst_if_pc", if_pc, 30'h0);
    chk("rst_if_insn", if_insn, 32'h0);
    cyc(); cyc();
    grant_cycle();
    chk("f1_bus_as", bus_as, 1'b1);
    chk("f1_bus_addr", bus_addr, 30'h100);
    cyc();
    bus_ready = 1'b1; bus_rd_data = 32'hA5A5_0001;
    #1;
    chk("f1_busy_ready", busy, 1'b0);
    cyc();
    bus_ready = 1'b0;
    chk("f1_if_en", if_en, 1'b1);
    chk("f1_if_insn", if_insn, 32'hA5A5_0001);
    chk("f1_if_pc", if_pc, 30'h101);
    chk("model_f1_if_pc", m_if_pc, 30'h101);
    grant_cycle();
    chk("f2_bus_addr", bus_addr, 30'h101);

    // Stall across bus_ready parks the word
    stall = 1'b1; bus_ready = 1'b1; bus_rd_data = 32'h0000_1234;
    cyc();
    bus_ready = 1'b0;
    chk("hold_busy", busy, 1'b0);
    chk("hold_bus_req", bus_req, 1'b0);
    chk("hold_if_insn", if_insn, 32'hA5A5_0001);
    cyc(); cyc();
    chk("hold_if_en", if_en, 1'b0);
    stall = 1'b0;
    cyc();
    chk("unhold_if_insn", if_insn, 32'h0000_1234);
    chk("unhold_if_en", if_en, 1'b1);
    chk("unhold_if_pc", if_pc, 30'h102);
    grant_cycle();
    chk("unhold_next_addr", bus_addr, 30'h102);

    // Flush while the read is outstanding drains it
    flush = 1'b1; new_pc = 30'h40;
    cyc();
    flush = 1'b0;
    chk("drain_if_en", if_en, 1'b0);
    chk("drain_busy", busy, 1'b1);
    cyc();
    bus_ready = 1'b1; bus_rd_data = 32'hDEAD_BEEF;
    #1;
    chk("drain_busy_ready", busy, 1'b1);
    cyc();
    bus_ready = 1'b0;
    chk("drain_discard_insn", if_insn, 32'h0000_1234);
    chk("drain_discard_en", if_en, 1'b0);
    grant_cycle();
    chk("drain_next_as", bus_as, 1'b1);
    chk("drain_next_addr", bus_addr, 30'h40);

    // Branch taken at delivery, then flush beating a branch
    flush = 1'b1; new_pc = 30'h10;
    cyc();
    flush = 1'b0; bus_ready = 1'b1;
    cyc();
    bus_ready = 1'b0;
    grant_cycle();
    chk("br_fetch_addr", bus_addr, 30'h10);
    bus_ready = 1'b1; bus_rd_data = 32'h55; br_taken = 1'b1; br_addr = 30'h80;
    cyc();
    clear_ctl();
    chk("br_if_pc", if_pc, 30'h11);
    chk("br_if_en", if_en, 1'b1);
    grant_cycle();
    chk("br_target_addr", bus_addr, 30'h80);
    bus_ready = 1'b1; br_taken = 1'b1; br_addr = 30'h80; flush = 1'b1; new_pc = 30'h20;
    cyc();
    clear_ctl();
    chk("brfl_if_en", if_en, 1'b0);
    grant_cycle();
    chk("brfl_addr", bus_addr, 30'h20);

    // PC wrap
    flush = 1'b1; new_pc = '1; bus_ready = 1'b1;
    cyc();
    clear_ctl();
    grant_cycle();
    chk("wrap_fetch_addr", bus_addr, 30'h3FFF_FFFF);
    bus_ready = 1'b1; bus_rd_data = 32'h77;
    cyc();
    bus_ready = 1'b0;
    chk("wrap_if_pc", if_pc, 30'h0);
    chk("wrap_if_insn", if_insn, 32'h77);
    grant_cycle();
    chk("wrap_next_addr", bus_addr, 30'h0);

    // Reset mid-access
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("midrst_bus_req", bus_req, 1'b0);
    chk("midrst_if_en", if_en, 1'b0);
    chk("midrst_busy", busy, 1'b1);
    grant_cycle();
    chk("midrst_as", bus_as, 1'b1);
    chk("midrst_addr", bus_addr, 30'h100);
    chk("model_midrst_addr", m_addr, 30'h100);

    // Randomized traffic
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b1;
        ag_pending = 1'b0;
        clear_ctl();
      end else begin
        reset = 1'b0;
        bus_step();
        stall    = ($urandom_range(0, 3) == 0);
        flush    = ($urandom_range(0, 11) == 0);
        new_pc   = ($urandom_range(0, 7) == 0) ? '1 : AW'($urandom);
        br_taken = ($urandom_range(0, 3) == 0);
        br_addr  = ($urandom_range(0, 7) == 0) ? '1 : AW'($urandom);
      end
      cyc();
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
